// File: rtl/vram_pkg.sv
// Shared VideoRAM definitions: word geometry and the field layout of a text cell.
package vram_pkg;

  localparam int VRAM_ADDR_W = 12;
  localparam int VRAM_DATA_W = 18;

  localparam int BLINK_LSB = 16;
  localparam int COLOR_LSB = 8;
  localparam int CHAR_LSB  = 0;

  typedef struct packed {
    logic [1:0] blink;
    logic [7:0] color;
    logic [7:0] chr;
  } vram_word_t;

  // Assemble a RAM word from its blink/color/char fields.
  function automatic logic [VRAM_DATA_W-1:0] pack_word(input logic [1:0] blink,
                                                        input logic [7:0] color,
                                                        input logic [7:0] chr);
    logic [VRAM_DATA_W-1:0] w;
    w = '0;
    w[BLINK_LSB +: 2] = blink;
    w[COLOR_LSB +: 8] = color;
    w[CHAR_LSB  +: 8] = chr;
    return w;
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Generic synchronous FIFO with combinational head output and an occupancy count.
// A push on a full FIFO is accepted only when a pop retires an entry in the same cycle.
module vram_wr_fifo #(
  parameter  int WIDTH = 30,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is not reset; clearing the pointers is enough to discard pending entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/vram_write_buffer.sv
// Buffers decoder write requests and retires them to the VideoRAM port only in
// cycles the display fetch leaves free. Requests that cannot be held are dropped and flagged.
module vram_write_buffer
  import vram_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int ADDR_W = VRAM_ADDR_W,
  parameter  int DATA_W = VRAM_DATA_W,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              PixClk5,
  input  logic              nReset,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              WrEn,
  input  logic              DispBusy,
  input  logic              ClrOverflow,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [DATA_W-1:0] RamData,
  output logic              RamWe,
  output logic [LVL_W-1:0]  Level,
  output logic              Overflow
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [ENTRY_W-1:0] head;
  logic               fifo_full, fifo_empty;
  logic               pop, drop;

  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]  ram_data_q, ram_data_d;
  logic               ram_we_q, ram_we_d;
  logic               overflow_q, overflow_d;

  // The RAM port is ours whenever the display is not fetching and something is queued.
  assign pop  = !fifo_empty && !DispBusy;
  assign drop = WrEn && fifo_full && !pop;

  vram_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (PixClk5),
    .rst_n   (nReset),
    .push_i  (WrEn),
    .pop_i   (pop),
    .din_i   ({WrAddr, WrData}),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (Level)
  );

  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = 1'b0;
    overflow_d = overflow_q;
    if (pop) begin
      ram_addr_d = head[ENTRY_W-1:DATA_W];
      ram_data_d = head[DATA_W-1:0];
      ram_we_d   = 1'b1;
    end
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)             overflow_d = 1'b1;
    else if (ClrOverflow) overflow_d = 1'b0;
  end

  always_ff @(posedge PixClk5 or negedge nReset) begin
    if (!nReset) begin
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
      overflow_q <= overflow_d;
    end
  end

  assign RamAddr  = ram_addr_q;
  assign RamData  = ram_data_q;
  assign RamWe    = ram_we_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_vram_write_buffer.sv
// Directed bench for vram_write_buffer: inputs change on the falling edge,
// outputs are checked on the following falling edge.
module tb_vram_write_buffer;
  import vram_pkg::*;

  logic        PixClk5 = 1'b0;
  logic        nReset;
  logic [11:0] WrAddr;
  logic [17:0] WrData;
  logic        WrEn;
  logic        DispBusy;
  logic        ClrOverflow;
  logic [11:0] RamAddr;
  logic [17:0] RamData;
  logic        RamWe;
  logic [4:0]  Level;
  logic        Overflow;

  int total  = 0;
  int passed = 0;

  vram_write_buffer #(.DEPTH(16), .ADDR_W(12), .DATA_W(18)) dut (
    .PixClk5     (PixClk5),
    .nReset      (nReset),
    .WrAddr      (WrAddr),
    .WrData      (WrData),
    .WrEn        (WrEn),
    .DispBusy    (DispBusy),
    .ClrOverflow (ClrOverflow),
    .RamAddr     (RamAddr),
    .RamData     (RamData),
    .RamWe       (RamWe),
    .Level       (Level),
    .Overflow    (Overflow)
  );

  always #5 PixClk5 = ~PixClk5;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One rising edge, then settle on the falling edge where checks and new inputs happen.
  task automatic tick();
    @(posedge PixClk5);
    @(negedge PixClk5);
  endtask

  task automatic put(input logic [11:0] a, input logic [17:0] d);
    WrEn = 1'b1; WrAddr = a; WrData = d;
    tick();
  endtask

  initial begin
    nReset = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0;
    DispBusy = 1'b0; ClrOverflow = 1'b0;
    #12;
    check("rst_we", 32'(RamWe), 0);
    check("rst_addr", 32'(RamAddr), 0);
    check("rst_data", 32'(RamData), 0);
    check("rst_level", 32'(Level), 0);
    check("rst_ovf", 32'(Overflow), 0);
    @(negedge PixClk5);
    nReset = 1'b1;
    tick();

    // Single write: retired one edge after it is captured.
    put(12'h123, pack_word(2'd2, 8'h41, 8'h48));
    WrEn = 1'b0;
    check("single_lvl1", 32'(Level), 1);
    check("single_we0", 32'(RamWe), 0);
    tick();
    check("single_we", 32'(RamWe), 1);
    check("single_addr", 32'(RamAddr), 32'h123);
    check("single_data", 32'(RamData), 32'h24148);
    check("single_lvl0", 32'(Level), 0);
    tick();
    check("single_we_off", 32'(RamWe), 0);
    check("single_addr_hold", 32'(RamAddr), 32'h123);
    $display("txn single write done");

    // Burst of 10 held off by DispBusy, then drained in order.
    DispBusy = 1'b1;
    for (int i = 0; i < 10; i++) put(12'(i), 18'(32'h100 + i));
    WrEn = 1'b0;
    check("burst_lvl", 32'(Level), 10);
    check("burst_we_busy", 32'(RamWe), 0);
    DispBusy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("burst_we", 32'(RamWe), 1);
      check("burst_addr", 32'(RamAddr), 32'(i));
      check("burst_data", 32'(RamData), 32'h100 + 32'(i));
      check("burst_lvl_drain", 32'(Level), 32'(9 - i));
    end
    tick();
    check("burst_we_end", 32'(RamWe), 0);
    $display("txn burst under busy done");

    // Overflow: 20 writes into a 16-deep buffer; only the first 16 survive.
    DispBusy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      put(12'(i), 18'(i));
      if (i == 15) check("ovf_not_yet", 32'(Overflow), 0);
    end
    WrEn = 1'b0;
    check("ovf_lvl", 32'(Level), 16);
    check("ovf_flag", 32'(Overflow), 1);
    DispBusy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("ovf_drain_addr", 32'(RamAddr), 32'(i));
      check("ovf_drain_we", 32'(RamWe), 1);
    end
    tick();
    check("ovf_no_extra", 32'(RamWe), 0);
    check("ovf_empty", 32'(Level), 0);
    check("ovf_sticky", 32'(Overflow), 1);
    ClrOverflow = 1'b1;
    tick();
    ClrOverflow = 1'b0;
    check("ovf_cleared", 32'(Overflow), 0);
    $display("txn overflow done");

    // Full FIFO with simultaneous push and pop: nothing dropped.
    DispBusy = 1'b1;
    for (int i = 0; i < 16; i++) put(12'(32'h200 + i), 18'(i));
    check("full_lvl", 32'(Level), 16);
    DispBusy = 1'b0;
    for (int j = 0; j < 5; j++) begin
      put(12'(32'h300 + j), 18'(32'h300 + j));
      check("full_pp_lvl", 32'(Level), 16);
      check("full_pp_ovf", 32'(Overflow), 0);
      check("full_pp_addr", 32'(RamAddr), 32'h200 + 32'(j));
    end
    WrEn = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("full_drain_addr", 32'(RamAddr), (k < 11) ? 32'h205 + 32'(k) : 32'h300 + 32'(k - 11));
    end
    tick();
    check("full_drain_lvl", 32'(Level), 0);
    $display("txn full push/pop done");

    // Reset mid-burst: Level=7 with a write in flight.
    DispBusy = 1'b1;
    for (int i = 0; i < 8; i++) put(12'(32'h400 + i), 18'(i));
    WrEn = 1'b0;
    DispBusy = 1'b0;
    tick();
    check("mid_lvl", 32'(Level), 7);
    check("mid_we", 32'(RamWe), 1);
    #2 nReset = 1'b0;
    #1;
    check("mid_rst_we", 32'(RamWe), 0);
    check("mid_rst_addr", 32'(RamAddr), 0);
    check("mid_rst_data", 32'(RamData), 0);
    check("mid_rst_lvl", 32'(Level), 0);
    tick();
    nReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_we", 32'(RamWe), 0);
      check("post_rst_lvl", 32'(Level), 0);
    end
    $display("txn mid-burst reset done");

    // Clear and drop in the same cycle: the set wins.
    DispBusy = 1'b1;
    for (int i = 0; i < 16; i++) put(12'(i), 18'(i));
    check("sw_pre_ovf", 32'(Overflow), 0);
    ClrOverflow = 1'b1;
    put(12'hFFF, 18'h3FFFF);
    WrEn = 1'b0;
    ClrOverflow = 1'b0;
    check("sw_ovf", 32'(Overflow), 1);
    check("sw_lvl", 32'(Level), 16);
    $display("txn set-wins done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
